// File: rtl/inst_fetcher.sv
// Fetch stage: owns the PC, issues one ICache word fetch at a time, predicts the next PC
// (2-bit BHT for branches, JAL taken, everything else fall-through) and buffers one instruction for the IQ.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned BHT_IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        IC_req_valid,
  output logic [31:0] IC_req_addr,
  input  logic        IC_resp_valid,
  input  logic [31:0] IC_resp_inst,
  input  logic        IQ_is_full,
  output logic        IQ_input_valid,
  output logic [31:0] IQ_inst,
  output logic [31:0] IQ_inst_pc,
  output logic        IQ_predicted_to_jump,
  output logic [31:0] IQ_predicted_pc,
  input  logic        ROB_roll_back_flag,
  input  logic [31:0] ROB_target_pc,
  input  logic        ROB_br_commit,
  input  logic [31:0] ROB_br_pc,
  input  logic        ROB_br_taken
);

  localparam int unsigned BHT_SIZE = 1 << BHT_IDX_W;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                 state;
  logic [31:0]            pc;
  logic                   buf_valid;
  logic [1:0]             bht [BHT_SIZE];

  logic [BHT_IDX_W-1:0]   fetch_idx;
  logic [BHT_IDX_W-1:0]   commit_idx;
  logic [31:0]            j_imm;
  logic [31:0]            b_imm;
  logic                   pred_taken;
  logic [31:0]            pred_pc;
  logic                   unused_br_pc_bits;

  assign fetch_idx         = IC_req_addr[BHT_IDX_W+1:2];
  assign commit_idx        = ROB_br_pc[BHT_IDX_W+1:2];
  assign unused_br_pc_bits = ^{ROB_br_pc[31:BHT_IDX_W+2], ROB_br_pc[1:0]};

  assign j_imm = {{11{IC_resp_inst[31]}}, IC_resp_inst[31], IC_resp_inst[19:12],
                  IC_resp_inst[20], IC_resp_inst[30:21], 1'b0};
  assign b_imm = {{19{IC_resp_inst[31]}}, IC_resp_inst[31], IC_resp_inst[7],
                  IC_resp_inst[30:25], IC_resp_inst[11:8], 1'b0};

  // IC_req_addr is the PC of the word in flight, so it drives both BHT lookup and target math.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = IC_req_addr + 32'd4;
    case (IC_resp_inst[6:0])
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_pc    = IC_req_addr + j_imm;
      end
      OP_BRANCH: begin
        if (bht[fetch_idx][1]) begin
          pred_taken = 1'b1;
          pred_pc    = IC_req_addr + b_imm;
        end
      end
      default: ;
    endcase
  end

  assign IQ_input_valid = buf_valid & ~IQ_is_full & rdy & ~ROB_roll_back_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (rdy && ROB_br_commit) begin
      if (ROB_br_taken) begin
        if (bht[commit_idx] != 2'b11) bht[commit_idx] <= bht[commit_idx] + 2'd1;
      end else begin
        if (bht[commit_idx] != 2'b00) bht[commit_idx] <= bht[commit_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      pc                   <= RESET_PC;
      buf_valid            <= 1'b0;
      IC_req_valid         <= 1'b0;
      IC_req_addr          <= '0;
      IQ_inst              <= '0;
      IQ_inst_pc           <= '0;
      IQ_predicted_to_jump <= 1'b0;
      IQ_predicted_pc      <= '0;
    end else if (rdy) begin
      if (ROB_roll_back_flag) begin
        buf_valid <= 1'b0;
        pc        <= ROB_target_pc;
        case (state)
          WAIT: begin
            if (IC_resp_valid) begin
              IC_req_valid <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= DROP;
            end
          end
          // A stale reply landing together with a rollback is consumed, so DROP has nothing left to wait for.
          DROP: begin
            if (IC_resp_valid) begin
              IC_req_valid <= 1'b0;
              state        <= IDLE;
            end
          end
          default: ;
        endcase
      end else begin
        if (IQ_input_valid) buf_valid <= 1'b0;
        case (state)
          IDLE: begin
            if (!buf_valid || IQ_input_valid) begin
              IC_req_valid <= 1'b1;
              IC_req_addr  <= pc;
              state        <= WAIT;
            end
          end
          WAIT: begin
            if (IC_resp_valid) begin
              IQ_inst              <= IC_resp_inst;
              IQ_inst_pc           <= IC_req_addr;
              IQ_predicted_to_jump <= pred_taken;
              IQ_predicted_pc      <= pred_pc;
              buf_valid            <= 1'b1;
              pc                   <= pred_pc;
              IC_req_valid         <= 1'b0;
              state                <= IDLE;
            end
          end
          DROP: begin
            if (IC_resp_valid) begin
              IC_req_valid <= 1'b0;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
